// File: rtl/seg_scan_decoder.sv
// Receiver for a multiplexed, active-low 4-digit seven-segment scan bus: rebuilds hex digits and dp/blank masks.
// Optional saturating error counter is built when SEG_SCAN_DECODER_ERR_CNT_EN is defined.
module seg_scan_decoder #(
    parameter int unsigned SETTLE        = 2,
    parameter int unsigned STABLE_FRAMES = 2,
    parameter logic [31:0] TIMEOUT       = 32'd1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] digits,
    output logic [3:0]  dp_mask,
    output logic [3:0]  blank_mask,
    output logic        digits_valid,
    output logic        update,
    output logic        an_err,
    output logic        code_err,
    output logic [7:0]  err_cnt
);

    localparam logic [3:0]  SETTLE_C  = 4'(SETTLE);
    localparam logic [3:0]  STABLE_C  = 4'(STABLE_FRAMES);
    localparam logic [31:0] TO_LAST_C = TIMEOUT - 32'd1;

    typedef struct packed {
        logic [3:0] value;
        logic       dp;
        logic       blank;
        logic       err;
    } slot_t;

    // Returns {legal, blank, value} for an active-low g..a segment code.
    function automatic logic [5:0] glyph_decode(input logic [6:0] code);
        logic [5:0] res;
        case (code)
            7'h40:   res = {1'b1, 1'b0, 4'h0};
            7'h79:   res = {1'b1, 1'b0, 4'h1};
            7'h24:   res = {1'b1, 1'b0, 4'h2};
            7'h30:   res = {1'b1, 1'b0, 4'h3};
            7'h19:   res = {1'b1, 1'b0, 4'h4};
            7'h12:   res = {1'b1, 1'b0, 4'h5};
            7'h02:   res = {1'b1, 1'b0, 4'h6};
            7'h78:   res = {1'b1, 1'b0, 4'h7};
            7'h00:   res = {1'b1, 1'b0, 4'h8};
            7'h10:   res = {1'b1, 1'b0, 4'h9};
            7'h08:   res = {1'b1, 1'b0, 4'hA};
            7'h03:   res = {1'b1, 1'b0, 4'hB};
            7'h46:   res = {1'b1, 1'b0, 4'hC};
            7'h21:   res = {1'b1, 1'b0, 4'hD};
            7'h06:   res = {1'b1, 1'b0, 4'hE};
            7'h0E:   res = {1'b1, 1'b0, 4'hF};
            7'h7F:   res = {1'b1, 1'b1, 4'h0};
            default: res = {1'b0, 1'b0, 4'h0};
        endcase
        return res;
    endfunction

    logic [7:0]  seg_r;
    logic [3:0]  an_r;
    logic [3:0]  an_prev_r;
    logic [3:0]  settle_cnt_r;
    slot_t [3:0] frame_r;
    slot_t [3:0] last_r;
    logic [3:0]  mask_r;
    logic [3:0]  stable_cnt_r;
    logic [31:0] to_cnt_r;
    logic [15:0] digits_r;
    logic [3:0]  dp_mask_r;
    logic [3:0]  blank_mask_r;
    logic        valid_r;
    logic        update_r;
    logic        an_err_r;
    logic        code_err_r;

    logic        an_same_s;
    logic        sample_s;
    logic        idle_s;
    logic        slot_s;
    logic        multi_s;
    logic        complete_s;
    logic        timeout_s;
    logic [1:0]  idx_s;
    logic [5:0]  glyph_s;
    slot_t       entry_s;
    logic [3:0]  mask_next_s;
    logic [15:0] frame_digits_s;
    logic [3:0]  frame_dp_s;
    logic [3:0]  frame_blank_s;
    logic        frame_err_s;
    logic        out_match_s;
    logic [3:0]  stable_next_s;
    logic        load_s;

    // A slot is taken exactly once, on the cycle the settle count would reach SETTLE.
    assign an_same_s  = (an_r == an_prev_r);
    assign sample_s   = an_same_s && (settle_cnt_r == (SETTLE_C - 4'd1));
    assign idle_s     = (an_r == 4'hF);
    assign slot_s     = sample_s && $onehot(~an_r);
    assign multi_s    = sample_s && !idle_s && !$onehot(~an_r);
    assign complete_s = (mask_r == 4'hF) && !multi_s;
    assign timeout_s  = (to_cnt_r == TO_LAST_C);
    assign glyph_s    = glyph_decode(seg_r[6:0]);
    assign entry_s    = {glyph_s[3:0], ~seg_r[7], glyph_s[4], ~glyph_s[5]};

    assign mask_next_s = ((multi_s || complete_s) ? 4'h0 : mask_r)
                       | (slot_s ? (4'b0001 << idx_s) : 4'h0);

    // Digit index of the single low enable bit.
    always_comb begin
        idx_s = 2'd0;
        case (an_r)
            4'b1110: idx_s = 2'd0;
            4'b1101: idx_s = 2'd1;
            4'b1011: idx_s = 2'd2;
            4'b0111: idx_s = 2'd3;
            default: idx_s = 2'd0;
        endcase
    end

    // Flattened view of the assembled frame for comparison and loading.
    always_comb begin
        frame_digits_s = 16'h0000;
        frame_dp_s     = 4'h0;
        frame_blank_s  = 4'h0;
        frame_err_s    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            frame_digits_s[i*4 +: 4] = frame_r[i].value;
            frame_dp_s[i]            = frame_r[i].dp;
            frame_blank_s[i]         = frame_r[i].blank;
            frame_err_s              = frame_err_s | frame_r[i].err;
        end
    end

    assign out_match_s = ({digits_r, dp_mask_r, blank_mask_r} ==
                          {frame_digits_s, frame_dp_s, frame_blank_s});

    // Stability counting and qualification of completed frames.
    always_comb begin
        stable_next_s = stable_cnt_r;
        load_s        = 1'b0;
        if (multi_s) begin
            stable_next_s = 4'd0;
        end else if (complete_s) begin
            if (frame_err_s) begin
                stable_next_s = 4'd0;
            end else if (frame_r == last_r) begin
                stable_next_s = (stable_cnt_r >= STABLE_C) ? STABLE_C : (stable_cnt_r + 4'd1);
            end else begin
                stable_next_s = 4'd1;
            end
            load_s = !frame_err_s && (stable_next_s == STABLE_C) && (!valid_r || !out_match_s);
        end else begin
            stable_next_s = stable_cnt_r;
        end
        if (timeout_s) begin
            stable_next_s = 4'd0;
            load_s        = 1'b0;
        end else begin
            load_s = load_s;
        end
    end

    // Input register and settle tracking of the enable lines.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_r        <= 8'hFF;
            an_r         <= 4'hF;
            an_prev_r    <= 4'hF;
            settle_cnt_r <= 4'd0;
        end else begin
            seg_r     <= seg;
            an_r      <= an;
            an_prev_r <= an_r;
            if (!an_same_s) begin
                settle_cnt_r <= 4'd0;
            end else if (settle_cnt_r != SETTLE_C) begin
                settle_cnt_r <= settle_cnt_r + 4'd1;
            end
        end
    end

    // Frame assembly, last-frame history and stability count.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_r      <= '0;
            last_r       <= '0;
            mask_r       <= 4'h0;
            stable_cnt_r <= 4'd0;
        end else begin
            mask_r       <= mask_next_s;
            stable_cnt_r <= stable_next_s;
            if (slot_s) begin
                frame_r[idx_s] <= entry_s;
            end
            if (complete_s) begin
                last_r <= frame_r;
            end
        end
    end

    // Inactivity timer, restarted by every single-digit sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_r <= 32'd0;
        end else if (slot_s) begin
            to_cnt_r <= 32'd0;
        end else if (!timeout_s) begin
            to_cnt_r <= to_cnt_r + 32'd1;
        end
    end

    // Registered outputs and status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            digits_r     <= 16'h0000;
            dp_mask_r    <= 4'h0;
            blank_mask_r <= 4'h0;
            valid_r      <= 1'b0;
            update_r     <= 1'b0;
            an_err_r     <= 1'b0;
            code_err_r   <= 1'b0;
        end else begin
            update_r   <= load_s;
            an_err_r   <= multi_s;
            code_err_r <= slot_s && !glyph_s[5];
            if (load_s) begin
                digits_r     <= frame_digits_s;
                dp_mask_r    <= frame_dp_s;
                blank_mask_r <= frame_blank_s;
            end
            if (timeout_s) begin
                valid_r <= 1'b0;
            end else if (load_s) begin
                valid_r <= 1'b1;
            end
        end
    end

`ifdef SEG_SCAN_DECODER_ERR_CNT_EN
    logic [7:0] err_cnt_r;

    // Saturating count of enable and glyph errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_r <= 8'h00;
        end else if ((multi_s || (slot_s && !glyph_s[5])) && (err_cnt_r != 8'hFF)) begin
            err_cnt_r <= err_cnt_r + 8'h01;
        end
    end

    assign err_cnt = err_cnt_r;
`else
    assign err_cnt = 8'h00;
`endif

    assign digits       = digits_r;
    assign dp_mask      = dp_mask_r;
    assign blank_mask   = blank_mask_r;
    assign digits_valid = valid_r;
    assign update       = update_r;
    assign an_err       = an_err_r;
    assign code_err     = code_err_r;

endmodule
